pci_reg_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single-port UART register bank between NREQ local requesters.

---
 rtl/pci_reg_arbiter_pkg.sv | 15 +
 rtl/pci_reg_arbiter_rr_pick.sv | 33 +++
 rtl/pci_reg_arbiter.sv | 147 ++++++++++++++
 tb/tb_pci_reg_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_reg_arbiter_pkg.sv
// Shared definitions for the PCI/UART register-bank arbiter:
// FSM state encoding, requester index constants and the byte-enable width.
package pci_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam int REQ_PCI  = 0;
  localparam int REQ_UART = 1;
  localparam int BE_W     = 4;

endpackage

// File: rtl/pci_reg_arbiter_rr_pick.sv
// rr_pick: combinational circular priority picker. Grants the first requester
// strictly after the one-hot last winner, wrapping around to index 0.
module pci_reg_arbiter_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] winner
);

  logic [NREQ-1:0] above_last;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] masked_lsb;
  logic [NREQ-1:0] req_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      if (gi == 0) begin : g_first
        assign above_last[gi] = 1'b0;
      end else begin : g_rest
        assign above_last[gi] = |last[gi-1:0];
      end
    end
  endgenerate

  // Requesters above the last winner take precedence; otherwise wrap to the lowest index.
  assign masked     = req & above_last;
  assign masked_lsb = masked & (~masked + 1'b1);
  assign req_lsb    = req & (~req + 1'b1);
  assign winner     = (|masked) ? masked_lsb : req_lsb;

endmodule

// File: rtl/pci_reg_arbiter.sv
// Round-robin arbiter sharing the single-port UART register bank between NREQ requesters.
// Optional: define PCI_ARB_TIMEOUT_EN to enable the bus_ack watchdog (err + all-ones rdata).
module pci_reg_arbiter
  import pci_reg_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*BE_W-1:0]     req_be,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [BE_W-1:0]          bus_be,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic                     bus_ack
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] LAST_INIT = {1'b1, {(NREQ-1){1'b0}}};

  arb_state_t        state_reg;
  logic [NREQ-1:0]   last_reg;
  logic [NREQ-1:0]   pick;
  logic [IDX_W-1:0]  pick_idx;

  logic [BE_W-1:0]   be_arr    [NREQ];
  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign be_arr[gi]    = req_be[gi*BE_W +: BE_W];
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  pci_reg_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req),
    .last   (last_reg),
    .winner (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign busy = (state_reg != ST_IDLE);

`ifdef PCI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] cnt_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      last_reg  <= LAST_INIT;
      grant     <= '0;
      ack       <= '0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef PCI_ARB_TIMEOUT_EN
      err       <= 1'b0;
      cnt_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            bus_we    <= req_we[pick_idx];
            bus_be    <= be_arr[pick_idx];
            bus_addr  <= addr_arr[pick_idx];
            bus_wdata <= wdata_arr[pick_idx];
            grant     <= pick;
            bus_req   <= 1'b1;
            state_reg <= ST_BUS;
`ifdef PCI_ARB_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
          end
        end

        ST_BUS: begin
          // A real bus_ack always beats a watchdog expiry on the same edge.
          if (bus_ack) begin
            rdata     <= bus_we ? '0 : bus_rdata;
            ack       <= grant;
            bus_req   <= 1'b0;
            state_reg <= ST_DONE;
`ifdef PCI_ARB_TIMEOUT_EN
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            rdata     <= '1;
            err       <= 1'b1;
            ack       <= grant;
            bus_req   <= 1'b0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
`endif
          end
        end

        ST_DONE: begin
          ack       <= '0;
          last_reg  <= grant;
          grant     <= '0;
          state_reg <= ST_IDLE;
`ifdef PCI_ARB_TIMEOUT_EN
          err       <= 1'b0;
`endif
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_reg_arbiter.sv
// Self-checking bench for pci_reg_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_pci_reg_arbiter;
  import pci_reg_arbiter_pkg::*;

  localparam int NREQ    = 2;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*4-1:0]      req_be;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   bus_req;
  logic                   bus_we;
  logic [3:0]             bus_be;
  logic [ADDR_W-1:0]      bus_addr;
  logic [DATA_W-1:0]      bus_wdata;
  logic [DATA_W-1:0]      bus_rdata;
  logic                   bus_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pci_reg_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .grant     (grant),
    .busy      (busy),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  task automatic set_cmd(input int i, input logic we, input logic [3:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_we[i]                   = we;
    req_be[i*4 +: 4]            = be;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Reference: first requester after the last winner in circular order.
  function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (last + off) % NREQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== '0 || grant !== '0 || busy !== 1'b0 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ack=%b grant=%b busy=%b bus_req=%b, want all 0", ack, grant, busy, bus_req);
    end
    total++;
    if (rdata !== '0 || err !== 1'b0 || bus_we !== 1'b0 || bus_be !== '0 || bus_addr !== '0 || bus_wdata !== '0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h err=%b we=%b be=%b addr=%h wdata=%h, want all 0",
               rdata, err, bus_we, bus_be, bus_addr, bus_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_cmd(REQ_PCI, 1'b0, 4'hF, 6'd4, '0);
    req = 2'b01;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1 || grant !== 2'b01 || bus_addr !== 6'd4 || bus_we !== 1'b0) begin
      bad++;
      $display("FAIL read_issue: bus_req=%b grant=%b addr=%0d we=%b, want 1 01 4 0", bus_req, grant, bus_addr, bus_we);
    end
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = '0;
    total++;
    if (ack !== 2'b01) begin
      bad++;
      $display("FAIL read_ack: ack=%b want 01", ack);
    end
    total++;
    if (rdata !== 32'h1234 || err !== 1'b0 || bus_req !== 1'b0) begin
      bad++;
      $display("FAIL read_data: rdata=%h err=%b bus_req=%b, want 00001234 0 0", rdata, err, bus_req);
    end
    req = '0;
    @(negedge clk);
    total++;
    if (ack !== '0 || busy !== 1'b0 || grant !== '0) begin
      bad++;
      $display("FAIL read_after: ack=%b busy=%b grant=%b, want 00 0 00", ack, busy, grant);
    end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] exp_seq [4];
    int n = 0, idle = 0, cyc = 0;
    bit in_acc = 1'b0;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    do_reset();
    set_cmd(REQ_PCI, 1'b0, 4'hF, 6'd1, '0);
    set_cmd(REQ_UART, 1'b0, 4'hF, 6'd2, '0);
    req = 2'b11;
    while (n < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      req = 2'b11;
      bus_ack = 1'b0;
      if (busy === 1'b0) idle++;
      if (bus_req === 1'b1 && !in_acc) begin
        in_acc = 1'b1;
        total++;
        if (grant !== exp_seq[n]) begin
          bad++;
          $display("FAIL rotate_grant%0d: grant=%b want %b", n, grant, exp_seq[n]);
        end
        if (n > 0) begin
          total++;
          if (idle != 1) begin
            bad++;
            $display("FAIL rotate_gap%0d: idle cycles=%0d want 1", n, idle);
          end
        end
        idle = 0;
        n++;
        bus_ack = 1'b1;
      end
      if (ack !== '0) begin
        in_acc = 1'b0;
        req = req & ~ack;
      end
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL rotate_count: accesses=%0d want 4", n);
    end
    bus_ack = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    do_reset();
    set_cmd(REQ_UART, 1'b1, 4'b0001, 6'd0, 32'h5);
    req = 2'b10;
    bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 6'd0 || bus_wdata !== 32'h5 ||
          bus_be !== 4'b0001 || grant !== 2'b10) begin
        bad++;
        $display("FAIL write_cmd%0d: req=%b we=%b addr=%0d wdata=%h be=%b grant=%b, want 1 1 0 5 0001 10",
                 c, bus_req, bus_we, bus_addr, bus_wdata, bus_be, grant);
      end
      if (c == 3) bus_ack = 1'b1;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    total++;
    if (ack !== 2'b10 || rdata !== '0) begin
      bad++;
      $display("FAIL write_ack: ack=%b rdata=%h, want 10 00000000", ack, rdata);
    end
    req = '0;
    bus_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cmd(REQ_PCI, 1'b0, 4'hF, 6'd7, '0);
    set_cmd(REQ_UART, 1'b0, 4'hF, 6'd8, '0);
    req = 2'b10;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: bus_req=%b want 1", bus_req);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus_req !== 1'b0 || grant !== '0 || busy !== 1'b0 || ack !== '0) begin
      bad++;
      $display("FAIL rstmid_async: bus_req=%b grant=%b busy=%b ack=%b, want all 0", bus_req, grant, busy, ack);
    end
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ack !== '0) begin
      bad++;
      $display("FAIL rstmid_idle: busy=%b ack=%b, want 0 00", busy, ack);
    end
    req = 2'b11;
    @(negedge clk);
    total++;
    if (grant !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_prio: grant=%b want 01", grant);
    end
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    req = '0;
    total++;
    if (ack !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_ack: ack=%b want 01", ack);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop();
    do_reset();
    set_cmd(REQ_UART, 1'b0, 4'hF, 6'd9, '0);
    set_cmd(REQ_PCI, 1'b0, 4'hF, 6'd10, '0);
    req = 2'b10;
    @(negedge clk);
    total++;
    if (grant !== 2'b10 || bus_req !== 1'b1) begin
      bad++;
      $display("FAIL drop_grant: grant=%b bus_req=%b, want 10 1", grant, bus_req);
    end
    req[REQ_PCI] = 1'b1;
    @(negedge clk);
    req[REQ_PCI] = 1'b0;
    total++;
    if (grant !== 2'b10) begin
      bad++;
      $display("FAIL drop_hold: grant=%b want 10", grant);
    end
    bus_ack = 1'b1;
    bus_rdata = 32'hA5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    total++;
    if (ack !== 2'b10 || rdata !== 32'hA5A5) begin
      bad++;
      $display("FAIL drop_ack: ack=%b rdata=%h, want 10 0000a5a5", ack, rdata);
    end
    req = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || bus_req !== 1'b0 || grant !== '0) begin
        bad++;
        $display("FAIL drop_idle%0d: busy=%b bus_req=%b grant=%b, want 0 0 00", c, busy, bus_req, grant);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit got = 1'b0;
    do_reset();
    set_cmd(REQ_PCI, 1'b0, 4'hF, 6'd3, '0);
    req = 2'b01;
`ifdef PCI_ARB_TIMEOUT_EN
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (ack !== '0) got = 1'b1;
      else if (bus_req === 1'b1) cnt++;
    end
    total++;
    if (!got || cnt != TIMEOUT) begin
      bad++;
      $display("FAIL timeout_cycles: ack seen=%0d bus_req cycles=%0d, want 1 %0d", got, cnt, TIMEOUT);
    end
    total++;
    if (rdata !== 32'hFFFFFFFF || err !== 1'b1 || ack !== 2'b01) begin
      bad++;
      $display("FAIL timeout_resp: rdata=%h err=%b ack=%b, want ffffffff 1 01", rdata, err, ack);
    end
    req = '0;
    @(negedge clk);
    total++;
    if (err !== 1'b0 || ack !== '0) begin
      bad++;
      $display("FAIL timeout_clear: err=%b ack=%b, want 0 00", err, ack);
    end
    req = 2'b01;
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (ack !== '0) got = 1'b1;
      else if (bus_req === 1'b1) begin
        cnt++;
        if (cnt == TIMEOUT) begin
          bus_ack = 1'b1;
          bus_rdata = 32'h600D;
        end
      end
    end
    total++;
    if (!got || rdata !== 32'h600D || err !== 1'b0 || ack !== 2'b01) begin
      bad++;
      $display("FAIL timeout_race: seen=%0d rdata=%h err=%b ack=%b, want 1 0000600d 0 01", got, rdata, err, ack);
    end
    req = '0;
    @(negedge clk);
`else
    repeat (3 * TIMEOUT) begin
      @(negedge clk);
      if (ack !== '0) got = 1'b1;
      if (bus_req === 1'b1) cnt++;
    end
    total++;
    if (got || bus_req !== 1'b1 || busy !== 1'b1 || cnt != 3 * TIMEOUT) begin
      bad++;
      $display("FAIL hang: ack seen=%0d bus_req=%b busy=%b cycles=%0d, want 0 1 1 %0d",
               got, bus_req, busy, cnt, 3 * TIMEOUT);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL hang_err: err=%b want 0", err);
    end
`endif
    do_reset();
  endtask

  task automatic test_random();
    int m = 0, cur = 0, last = NREQ - 1, delay = 0, done = 0, cyc = 0;
    int cool [NREQ];
    logic [DATA_W-1:0] exp_rd;
    logic [NREQ-1:0] oh;
    exp_rd = '0;
    do_reset();
    foreach (cool[i]) cool[i] = 0;
    while (done < 80 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      oh = '0;
      oh[cur] = 1'b1;
      total++;
      case (m)
        0: if (busy !== 1'b0 || bus_req !== 1'b0 || ack !== '0 || grant !== '0) begin
             bad++;
             $display("FAIL rand_idle: busy=%b bus_req=%b ack=%b grant=%b, want all 0", busy, bus_req, ack, grant);
           end
        1: if (bus_req !== 1'b1 || grant !== oh || bus_we !== req_we[cur] || bus_be !== req_be[cur*4 +: 4] ||
               bus_addr !== req_addr[cur*ADDR_W +: ADDR_W] || bus_wdata !== req_wdata[cur*DATA_W +: DATA_W]) begin
             bad++;
             $display("FAIL rand_bus: bus_req=%b grant=%b addr=%h wdata=%h, want 1 %b %h %h",
                      bus_req, grant, bus_addr, bus_wdata, oh,
                      req_addr[cur*ADDR_W +: ADDR_W], req_wdata[cur*DATA_W +: DATA_W]);
           end
        default: if (ack !== oh || rdata !== exp_rd || err !== 1'b0 || bus_req !== 1'b0) begin
             bad++;
             $display("FAIL rand_ack: ack=%b rdata=%h err=%b bus_req=%b, want %b %h 0 0",
                      ack, rdata, err, bus_req, oh, exp_rd);
           end
      endcase
      // Requesters: drop after ack, then randomly post new commands.
      if (m == 2) begin
        req[cur] = 1'b0;
        cool[cur] = $urandom_range(1, 3);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (cool[i] > 0) cool[i]--;
        else if (req[i] == 1'b0 && $urandom_range(0, 2) == 0) begin
          set_cmd(i, 1'($urandom_range(0, 1)), 4'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
          req[i] = 1'b1;
        end
      end
      // Register bank: random completion delay.
      bus_ack = 1'b0;
      if (m == 1) begin
        bus_rdata = DATA_W'($urandom);
        if (delay == 0) begin
          bus_ack = 1'b1;
          exp_rd = req_we[cur] ? '0 : bus_rdata;
        end else begin
          delay--;
        end
      end
      case (m)
        0: if (req != '0) begin
             cur = rr_model(req, last);
             delay = $urandom_range(0, 3);
             m = 1;
           end
        1: if (bus_ack) m = 2;
        default: begin
             last = cur;
             m = 0;
             done++;
           end
      endcase
    end
    total++;
    if (done < 80) begin
      bad++;
      $display("FAIL rand_progress: completed=%0d want 80", done);
    end
    bus_ack = 1'b0;
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rotation();
    test_write();
    test_reset_mid();
    test_drop();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
